generic_stream_demux: RTL and testbench

//  Counterpart of the flattened-bus mux: steers one DATA-wide input stream to
//  one of OUT output channels, presented on a single flattened output bus.

---
 rtl/generic_stream_demux.sv | 180 ++++++++++++++++++
 tb/tb_generic_stream_demux.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/generic_stream_demux.sv
// -----------------------------------------------------------------------------
// generic_stream_demux
//
// Purpose:
//   Steers one DATA-wide valid/ready input stream to one of OUT output
//   channels. Each channel owns a one-entry holding register with its own
//   valid/ready handshake, so a slow consumer stalls only the beats addressed
//   to its own channel. All channel registers are presented side by side on a
//   single flattened output bus.
//
// Parameters:
//   OUT   number of output channels (>= 2)
//   DATA  width of one data beat in bits
//   SELW  select width, derived as $clog2(OUT) (not overridable)
//
// Ports:
//   clk               in   1         rising-edge clock
//   rst_n             in   1         synchronous reset, active-low
//   in_valid          in   1         producer beat valid
//   in_ready          out  1         beat is accepted this cycle when in_valid=1
//   in_data           in   DATA      producer beat
//   in_sel            in   SELW      target channel index
//   flattened_output  out  OUT*DATA  channel i on bits [i*DATA +: DATA]
//   out_valid         out  OUT       per-channel valid
//   out_ready         in   OUT       per-channel consumer ready
//   sel_err           out  1         one-cycle pulse: beat dropped, sel >= OUT
//
// Build option:
//   DEMUX_RR_EN  when defined, in_sel is ignored and beats are distributed by
//                an internal round-robin pointer that advances on every
//                accepted beat (wrapping OUT-1 -> 0). sel_err is then tied 0.
//                When undefined, the target is in_sel and no pointer exists.
// -----------------------------------------------------------------------------
module generic_stream_demux #(
  parameter int OUT  = 4,
  parameter int DATA = 8,
  localparam int SELW = $clog2(OUT)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA-1:0]     in_data,
  input  logic [SELW-1:0]     in_sel,
  output logic [OUT*DATA-1:0] flattened_output,
  output logic [OUT-1:0]      out_valid,
  input  logic [OUT-1:0]      out_ready,
  output logic                sel_err
);

  // OUT expressed with one extra bit so the range check can see sel == OUT
  // and above without truncation.
  localparam logic [SELW:0] OUT_EXT = (SELW + 1)'(OUT);

  logic [SELW-1:0] tgt;           // channel the current beat is aimed at
  logic            tgt_in_range;  // tgt names a real channel
  logic [OUT-1:0]  tgt_hit;       // one-hot decode of tgt (all zero if out of range)
  logic [OUT-1:0]  ch_ready;      // channel can take a beat this cycle
  logic [OUT-1:0]  valid_q;
  logic            accept;

  logic            sel_err_q;
  logic            sel_err_d;

  // ---------------------------------------------------------------------------
  // Target selection
  // ---------------------------------------------------------------------------
`ifdef DEMUX_RR_EN
  localparam logic [SELW-1:0] LAST_CH = SELW'(OUT - 1);

  logic [SELW-1:0] rr_q;
  logic [SELW-1:0] rr_d;
  logic            unused_in_sel;

  // The select input has no meaning in round-robin mode.
  assign unused_in_sel = ^in_sel;
  assign tgt           = rr_q;

  // Pointer moves only on an accepted beat, so a stalled target keeps the
  // pointer (and therefore the stream order) in place.
  always_comb begin
    rr_d = rr_q;
    if (accept) begin
      rr_d = (rr_q == LAST_CH) ? '0 : rr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_q <= '0;
    end else begin
      rr_q <= rr_d;
    end
  end

  // The pointer can never leave the valid range, so nothing is ever dropped.
  always_comb begin
    sel_err_d = 1'b0;
  end
`else
  assign tgt = in_sel;

  // An accepted beat with no matching channel is discarded and flagged in the
  // following cycle.
  always_comb begin
    sel_err_d = accept & ~tgt_in_range;
  end
`endif

  assign tgt_in_range = ({1'b0, tgt} < OUT_EXT);

  // ---------------------------------------------------------------------------
  // Input handshake
  // ---------------------------------------------------------------------------
  // Out-of-range beats are always taken (and dropped) so a bad select can
  // never wedge the producer. Otherwise the beat waits only on its own
  // channel: empty, or being drained in this same cycle.
  assign in_ready = ~tgt_in_range | (|(tgt_hit & ch_ready));
  assign accept   = in_valid & in_ready;

  // ---------------------------------------------------------------------------
  // Per-channel holding registers
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < OUT; gi++) begin : g_ch
    logic            ch_valid_q;
    logic            ch_valid_d;
    logic [DATA-1:0] ch_data_q;
    logic [DATA-1:0] ch_data_d;
    logic            ch_load;
    logic            ch_drain;

    assign tgt_hit[gi]  = tgt_in_range & (tgt == SELW'(gi));
    assign ch_ready[gi] = ~ch_valid_q | out_ready[gi];
    assign ch_load      = accept & tgt_hit[gi];
    assign ch_drain     = ch_valid_q & out_ready[gi];

    // A load takes priority over a drain: when both happen together the new
    // beat replaces the departing one and valid stays high with no bubble.
    // On a plain drain the data register keeps its last value.
    always_comb begin
      ch_valid_d = ch_valid_q;
      ch_data_d  = ch_data_q;
      if (ch_load) begin
        ch_valid_d = 1'b1;
        ch_data_d  = in_data;
      end else if (ch_drain) begin
        ch_valid_d = 1'b0;
      end
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        ch_valid_q <= 1'b0;
        ch_data_q  <= '0;
      end else begin
        ch_valid_q <= ch_valid_d;
        ch_data_q  <= ch_data_d;
      end
    end

    assign valid_q[gi]                     = ch_valid_q;
    assign flattened_output[gi*DATA +: DATA] = ch_data_q;
  end

  assign out_valid = valid_q;

  // ---------------------------------------------------------------------------
  // Drop indication
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sel_err_q <= 1'b0;
    end else begin
      sel_err_q <= sel_err_d;
    end
  end

  assign sel_err = sel_err_q;

endmodule

// File: tb/tb_generic_stream_demux.sv
// -----------------------------------------------------------------------------
// tb_generic_stream_demux
//
// Drives two demux instances in lockstep with the same stimulus: a 4-channel
// instance and a 3-channel instance (where select value 3 is out of range).
// Each is compared every cycle with a per-channel model of held beats.
// Directed steps cover the reset state, in-order steering, a per-channel
// stall, drain+load in the same cycle and a dropped out-of-range beat (or the
// round-robin distribution when DEMUX_RR_EN is defined); a randomized phase
// with occasional resets follows.
// -----------------------------------------------------------------------------
module tb_generic_stream_demux;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [7:0]  in_data;
  logic [1:0]  in_sel;
  logic [3:0]  out_ready;

  logic        in_ready4;
  logic [31:0] bus4;
  logic [3:0]  vld4;
  logic        err4;

  logic        in_ready3;
  logic [23:0] bus3;
  logic [2:0]  vld3;
  logic        err3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  generic_stream_demux #(.OUT(4), .DATA(8)) dut4 (
    .clk              (clk),
    .rst_n            (rst_n),
    .in_valid         (in_valid),
    .in_ready         (in_ready4),
    .in_data          (in_data),
    .in_sel           (in_sel),
    .flattened_output (bus4),
    .out_valid        (vld4),
    .out_ready        (out_ready),
    .sel_err          (err4)
  );

  generic_stream_demux #(.OUT(3), .DATA(8)) dut3 (
    .clk              (clk),
    .rst_n            (rst_n),
    .in_valid         (in_valid),
    .in_ready         (in_ready3),
    .in_data          (in_data),
    .in_sel           (in_sel),
    .flattened_output (bus3),
    .out_valid        (vld3),
    .out_ready        (out_ready[2:0]),
    .sel_err          (err3)
  );

  // ---------------------------------------------------------------------------
  // Reference model: index 0 -> 4-channel instance, index 1 -> 3-channel.
  // Each channel is simply "holding a beat or not" plus the last beat stored.
  // ---------------------------------------------------------------------------
  logic       mv   [2][4];
  logic [7:0] md   [2][4];
  logic       merr [2];
  int         mrr  [2];

  function automatic int nch(input int k);
    return (k == 0) ? 4 : 3;
  endfunction

  function automatic int model_tgt(input int k, input logic [1:0] s);
`ifdef DEMUX_RR_EN
    return mrr[k];
`else
    return int'(s);
`endif
  endfunction

  function automatic logic model_ready(input int k, input logic [1:0] s, input logic [3:0] r);
    int t;
    t = model_tgt(k, s);
    if (t >= nch(k)) return 1'b1;
    return !mv[k][t] || r[t];
  endfunction

  function automatic logic [31:0] exp_bus(input int k);
    logic [31:0] b;
    b = '0;
    for (int i = 0; i < nch(k); i++) b[i*8 +: 8] = md[k][i];
    return b;
  endfunction

  function automatic logic [31:0] exp_vld(input int k);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < nch(k); i++) v[i] = mv[k][i];
    return v;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 4; i++) begin
        mv[k][i] = 1'b0;
        md[k][i] = 8'h00;
      end
      merr[k] = 1'b0;
      mrr[k]  = 0;
    end
  endtask

  task automatic model_edge(input logic v, input logic [1:0] s, input logic [7:0] d,
                            input logic [3:0] r);
    for (int k = 0; k < 2; k++) begin
      int   t;
      logic acc;
      t   = model_tgt(k, s);
      acc = v && model_ready(k, s, r);
      for (int i = 0; i < nch(k); i++) if (mv[k][i] && r[i]) mv[k][i] = 1'b0;
      if (acc && t < nch(k)) begin
        mv[k][t] = 1'b1;
        md[k][t] = d;
      end
`ifdef DEMUX_RR_EN
      merr[k] = 1'b0;
      if (acc) mrr[k] = (mrr[k] + 1) % nch(k);
`else
      merr[k] = acc && (t >= nch(k));
`endif
    end
  endtask

  // ---------------------------------------------------------------------------
  // Checking helpers
  // ---------------------------------------------------------------------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ":vld4"}, 32'(vld4), exp_vld(0));
    chk({tag, ":bus4"}, bus4,      exp_bus(0));
    chk({tag, ":err4"}, 32'(err4), 32'(merr[0]));
    chk({tag, ":vld3"}, 32'(vld3), exp_vld(1));
    chk({tag, ":bus3"}, 32'(bus3), exp_bus(1));
    chk({tag, ":err3"}, 32'(err3), 32'(merr[1]));
  endtask

  // One clock cycle: drive inputs, check in_ready mid-cycle, advance the
  // model at the edge, then check the registered outputs.
  task automatic step(input string tag, input logic v, input logic [1:0] s,
                      input logic [7:0] d, input logic [3:0] r);
    in_valid  = v;
    in_sel    = s;
    in_data   = d;
    out_ready = r;
    @(negedge clk);
    chk({tag, ":rdy4"}, 32'(in_ready4), 32'(model_ready(0, s, r)));
    chk({tag, ":rdy3"}, 32'(in_ready3), 32'(model_ready(1, s, r)));
    @(posedge clk);
    model_edge(v, s, d, r);
    #1;
    $display("step %-8s v=%0d sel=%0d data=%h rdy=%b -> vld4=%b bus4=%h err3=%0d",
             tag, v, s, d, r, vld4, bus4, err3);
    check_outputs(tag);
  endtask

  task automatic do_reset(input int cycles);
    rst_n    = 1'b0;
    in_valid = 1'b0;
    repeat (cycles) @(posedge clk);
    model_reset();
    #1;
    rst_n = 1'b1;
    $display("reset %0d cycles", cycles);
    check_outputs("reset");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_sel    = 2'd0;
    in_data   = 8'h00;
    out_ready = 4'b0000;
    model_reset();
    @(posedge clk);
    #1;

    // Reset state with constant expectations.
    do_reset(2);
    chk("rst_vld4", 32'(vld4), 32'h0);
    chk("rst_bus4", bus4, 32'h0);
    chk("rst_err4", 32'(err4), 32'h0);

`ifndef DEMUX_RR_EN
    // In-order steering, all consumers ready.
    step("t2_aa", 1'b1, 2'd0, 8'hAA, 4'b1111);
    step("t2_bb", 1'b1, 2'd1, 8'hBB, 4'b1111);
    step("t2_cc", 1'b1, 2'd2, 8'hCC, 4'b1111);
    step("t2_dd", 1'b1, 2'd3, 8'hDD, 4'b1111);
    chk("t2_bus", bus4, 32'hDDCCBBAA);
    chk("t2_vld", 32'(vld4), 32'h8);

    // Channel 2 stalled: second beat to ch2 blocked, ch1 unaffected.
    step("t3_11", 1'b1, 2'd2, 8'h11, 4'b1011);
    step("t3_22", 1'b1, 2'd2, 8'h22, 4'b1011);
    step("t3_33", 1'b1, 2'd1, 8'h33, 4'b1011);
    chk("t3_ch1", 32'(bus4[15:8]), 32'h33);
    chk("t3_ch2", 32'(bus4[23:16]), 32'h11);
    chk("t3_v2", 32'(vld4[2]), 32'h1);

    // Channel 0 full, drained and reloaded in the same cycle.
    step("t4_44", 1'b1, 2'd0, 8'h44, 4'b1110);
    chk("t4_v0a", 32'(vld4[0]), 32'h1);
    in_valid = 1'b1; in_sel = 2'd0; in_data = 8'h55; out_ready = 4'b1111;
    @(negedge clk);
    chk("t4_rdy", 32'(in_ready4), 32'h1);
    step("t4_55", 1'b1, 2'd0, 8'h55, 4'b1111);
    chk("t4_v0b", 32'(vld4[0]), 32'h1);
    chk("t4_ch0", 32'(bus4[7:0]), 32'h55);

    // Out-of-range select on the 3-channel instance.
    step("t5_77", 1'b1, 2'd3, 8'h77, 4'b0000);
    chk("t5_err", 32'(err3), 32'h1);
    step("t5_idle", 1'b0, 2'd0, 8'h00, 4'b0000);
    chk("t5_err0", 32'(err3), 32'h0);
`else
    // Round-robin distribution with wrap, then reset restarts the pointer.
    step("rr_a1", 1'b1, 2'd3, 8'hA1, 4'b1111);
    step("rr_a2", 1'b1, 2'd3, 8'hA2, 4'b1111);
    step("rr_a3", 1'b1, 2'd3, 8'hA3, 4'b1111);
    step("rr_a4", 1'b1, 2'd3, 8'hA4, 4'b1111);
    step("rr_a5", 1'b1, 2'd3, 8'hA5, 4'b1111);
    chk("rr_bus", bus4, 32'hA4A3A2A5);
    step("rr_b1", 1'b1, 2'd1, 8'hB1, 4'b1111);
    step("rr_b2", 1'b1, 2'd1, 8'hB2, 4'b1111);
    do_reset(1);
    step("rr_c1", 1'b1, 2'd2, 8'hC1, 4'b1111);
    chk("rr_rst0", 32'(vld4), 32'h1);
    chk("rr_c1d", 32'(bus4[7:0]), 32'hC1);
`endif

    // Randomized traffic with occasional mid-stream resets.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 59) == 0) begin
        do_reset(1 + $urandom_range(0, 1));
      end else begin
        step("rand", 1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
             8'($urandom), 4'($urandom));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
